// File: rtl/ancho_capture.sv
// ancho_capture: recovers period, high time and a 0..7 duty code from an incoming PWM waveform.
// Latency: results and the valid strobe appear about 3 clocks after the pin rise that closes a period.
// Backpressure: none; valid is a one-cycle strobe and results hold until the next measurement.
module ancho_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [2:0]       duty_code,
    output logic             valid,
    output logic             no_signal,
    output logic             stuck_level
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           state;
    logic             sync_meta;
    logic             s;
    logic             s_d;
    logic             rise;
    logic [CNT_W-1:0] cnt_p;
    logic [CNT_W-1:0] cnt_h;
    logic [CNT_W-1:0] cnt_p_inc;
    logic [CNT_W-1:0] cnt_h_inc;
    logic [CNT_W+2:0] high_x8;
    logic [CNT_W+2:0] period_xk;
    logic [2:0]       code;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
            s_d       <= 1'b0;
        end else begin
            sync_meta <= pwm_in;
            s         <= sync_meta;
            s_d       <= s;
        end
    end

    assign rise      = s & ~s_d;
    assign cnt_p_inc = (cnt_p == CNT_MAX) ? cnt_p : cnt_p + CNT_ONE;
    assign cnt_h_inc = (cnt_h == CNT_MAX) ? cnt_h : cnt_h + CNT_ONE;

    // Duty code counts k in 1..7 with 8*H >= k*N; k*N accumulates one N per step.
    always_comb begin
        high_x8   = {cnt_h, 3'b000};
        period_xk = '0;
        code      = '0;
        for (int k = 1; k < 8; k++) begin
            period_xk = period_xk + {3'b000, cnt_p};
            if (high_x8 >= period_xk) begin
                code = code + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt_p       <= '0;
            cnt_h       <= '0;
            period      <= '0;
            high_time   <= '0;
            duty_code   <= '0;
            valid       <= 1'b0;
            no_signal   <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                cnt_p <= '0;
                cnt_h <= '0;
                if (enable) begin
                    state <= ARM;
                end
            end else if (!enable) begin
                state <= IDLE;
                cnt_p <= '0;
                cnt_h <= '0;
            end else if (rise) begin
                // In ARM the first edge only opens a measurement window.
                if (state == MEASURE) begin
                    period    <= cnt_p;
                    high_time <= cnt_h;
                    duty_code <= code;
                    valid     <= 1'b1;
                    no_signal <= 1'b0;
                end
                state <= MEASURE;
                cnt_p <= CNT_ONE;
                cnt_h <= CNT_ONE;
            end else if (cnt_p == CNT_MAX) begin
                no_signal   <= 1'b1;
                stuck_level <= s;
                state       <= ARM;
                cnt_p       <= '0;
                cnt_h       <= '0;
            end else begin
                cnt_p <= cnt_p_inc;
                if (state == MEASURE && s) begin
                    cnt_h <= cnt_h_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_ancho_capture.sv
// Bench for ancho_capture: randomized and directed PWM waveforms checked against a timestamp-based model.
`timescale 1ns/1ps
module tb_ancho_capture;
    localparam int CNT_W = 10;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [2:0]       duty_code;
    logic             valid;
    logic             no_signal;
    logic             stuck_level;

    ancho_capture #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .duty_code   (duty_code),
        .valid       (valid),
        .no_signal   (no_signal),
        .stuck_level (stuck_level)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: measurement windows described by the cycle they opened in,
    // with high time taken from a history of the synchronised level.
    typedef enum {M_IDLE, M_ARM, M_MEAS} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      t       = 0;
    int      t_start = 0;
    bit      m_f1    = 0;
    bit      m_s     = 0;
    bit      m_sd    = 0;
    bit      hist [0:2047];
    int      m_period = 0;
    int      m_high   = 0;
    int      m_duty   = 0;
    logic    m_valid  = 1'b0;
    logic    m_ns     = 1'b0;
    logic    m_stuck  = 1'b0;
    int      w_len;
    int      w_high;

    function automatic int duty_of(int h, int p);
        int n = 0;
        for (int k = 1; k <= 7; k++) if (8 * h >= k * p) n++;
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase = M_IDLE;
            m_f1 = 0; m_s = 0; m_sd = 0;
            m_period = 0; m_high = 0; m_duty = 0;
            m_valid = 1'b0; m_ns = 1'b0; m_stuck = 1'b0;
            t_start = 0;
        end else begin
            hist[t % 2048] = m_s;
            m_valid = 1'b0;
            if (m_phase == M_IDLE) begin
                if (enable) begin
                    m_phase = M_ARM;
                    t_start = t + 1;
                end
            end else if (!enable) begin
                m_phase = M_IDLE;
            end else if (m_s && !m_sd) begin
                if (m_phase == M_MEAS) begin
                    w_len  = (t - t_start > MAXC) ? MAXC : t - t_start;
                    w_high = 0;
                    for (int i = t_start; i < t; i++) w_high += int'(hist[i % 2048]);
                    if (w_high > MAXC) w_high = MAXC;
                    m_period = w_len;
                    m_high   = w_high;
                    m_duty   = duty_of(w_high, w_len);
                    m_valid  = 1'b1;
                    m_ns     = 1'b0;
                end
                m_phase = M_MEAS;
                t_start = t;
            end else if (t - t_start >= MAXC) begin
                m_ns    = 1'b1;
                m_stuck = m_s;
                m_phase = M_ARM;
                t_start = t + 1;
            end
            m_sd = m_s;
            m_s  = m_f1;
            m_f1 = pwm_in;
            t++;
        end
    end

    function automatic string dut_str();
        return $sformatf("v=%b p=%0d h=%0d d=%0d ns=%b st=%b", valid, period, high_time, duty_code, no_signal, stuck_level);
    endfunction

    function automatic string mdl_str();
        return $sformatf("v=%b p=%0d h=%0d d=%0d ns=%b st=%b", m_valid, m_period, m_high, m_duty, m_ns, m_stuck);
    endfunction

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({period, high_time, duty_code, valid, no_signal, stuck_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %s, required all zero", dut_str());
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if ({period, high_time, duty_code, valid, no_signal, stuck_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got %s, required all zero", dut_str());
        end
    endtask

    task automatic test_basic();
        int nv = 0;
        int first = -1;
        enable = 1'b1;
        for (int c = 0; c < 36; c++) begin
            pwm_in = ((c % 8) < 3);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL basic c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
            if (valid) begin
                nv++;
                if (first < 0) first = c;
            end
        end
        n_chk++;
        if (nv !== 4 || first !== 10) begin
            n_fail++;
            $display("FAIL basic_strobes: got %0d valids first at %0d, required 4 first at 10", nv, first);
        end
        n_chk++;
        if (int'(period) !== 8 || int'(high_time) !== 3 || duty_code !== 3'd3) begin
            n_fail++;
            $display("FAIL basic_result: got %s, required p=8 h=3 d=3", dut_str());
        end
    endtask

    task automatic test_timeout_high();
        int nv = 0;
        for (int c = 0; c < 64; c++) begin
            pwm_in = ((c % 16) < 8);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL p16 c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
        end
        n_chk++;
        if (int'(period) !== 16 || int'(high_time) !== 8 || duty_code !== 3'd4) begin
            n_fail++;
            $display("FAIL p16_result: got %s, required p=16 h=8 d=4", dut_str());
        end
        for (int c = 0; c < MAXC + 40; c++) begin
            pwm_in = 1'b1;
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL stuck_high c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
            if (valid) nv++;
        end
        n_chk++;
        if (nv !== 1 || no_signal !== 1'b1 || stuck_level !== 1'b1 ||
            int'(period) !== 16 || int'(high_time) !== 8 || duty_code !== 3'd4) begin
            n_fail++;
            $display("FAIL stuck_high_result: got %s valids=%0d, required ns=1 st=1 p=16 h=8 d=4 valids=1", dut_str(), nv);
        end
    endtask

    task automatic test_low_resume();
        int nv = 0;
        for (int c = 0; c < 1100; c++) begin
            pwm_in = 1'b0;
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL stuck_low c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
        end
        n_chk++;
        if (no_signal !== 1'b1 || stuck_level !== 1'b0 || int'(period) !== 16) begin
            n_fail++;
            $display("FAIL stuck_low_result: got %s, required ns=1 st=0 p=16", dut_str());
        end
        for (int c = 0; c < 50; c++) begin
            pwm_in = ((c % 10) < 1);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL resume c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
            if (valid) nv++;
        end
        n_chk++;
        if (nv !== 4 || no_signal !== 1'b0 || int'(period) !== 10 || int'(high_time) !== 1 || duty_code !== 3'd0) begin
            n_fail++;
            $display("FAIL resume_result: got %s valids=%0d, required ns=0 p=10 h=1 d=0 valids=4", dut_str(), nv);
        end
    endtask

    task automatic test_duty_edges();
        for (int c = 0; c < 40; c++) begin
            pwm_in = ((c % 8) < 7);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL duty7 c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
        end
        n_chk++;
        if (int'(period) !== 8 || int'(high_time) !== 7 || duty_code !== 3'd7) begin
            n_fail++;
            $display("FAIL duty7_result: got %s, required p=8 h=7 d=7", dut_str());
        end
        for (int c = 0; c < 45; c++) begin
            pwm_in = ((c % 9) < 1);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL duty0 c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
        end
        n_chk++;
        if (int'(period) !== 9 || int'(high_time) !== 1 || duty_code !== 3'd0) begin
            n_fail++;
            $display("FAIL duty0_result: got %s, required p=9 h=1 d=0", dut_str());
        end
    endtask

    task automatic test_enable_gap();
        int first_after = -1;
        for (int c = 0; c < 90; c++) begin
            pwm_in = ((c % 12) < 5);
            enable = !(c >= 50 && c < 55);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL en_gap c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
            if (c == 60) begin
                n_chk++;
                if (int'(period) !== 12 || int'(high_time) !== 5 || duty_code !== 3'd3) begin
                    n_fail++;
                    $display("FAIL en_gap_hold: got %s, required p=12 h=5 d=3", dut_str());
                end
            end
            if (valid && c >= 50 && first_after < 0) first_after = c;
        end
        n_chk++;
        if (first_after !== 74) begin
            n_fail++;
            $display("FAIL en_gap_first: got first valid at %0d, required 74", first_after);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 35; c++) begin
            pwm_in = ((c % 10) < 4);
            @(negedge clock);
        end
        n_chk++;
        if (int'(period) !== 10 || int'(high_time) !== 4 || duty_code !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset: got %s, required p=10 h=4 d=3", dut_str());
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({period, high_time, duty_code, valid, no_signal, stuck_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %s, required all zero", dut_str());
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 45; c++) begin
            pwm_in = ((c % 10) < 4);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL after_reset c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
        end
        n_chk++;
        if (int'(period) !== 10 || int'(high_time) !== 4 || duty_code !== 3'd3) begin
            n_fail++;
            $display("FAIL after_reset_result: got %s, required p=10 h=4 d=3", dut_str());
        end
    endtask

    task automatic test_max_period();
        for (int c = 0; c < 3 * MAXC + 10; c++) begin
            pwm_in = ((c % MAXC) < 5);
            @(negedge clock);
            n_chk++;
            if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                n_fail++;
                $display("FAIL max_period c=%0d: got %s, required %s", c, dut_str(), mdl_str());
            end
        end
        n_chk++;
        if (int'(period) !== MAXC || int'(high_time) !== 5 || duty_code !== 3'd0 || no_signal !== 1'b0) begin
            n_fail++;
            $display("FAIL max_period_result: got %s, required p=%0d h=5 d=0 ns=0", dut_str(), MAXC);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int per = $urandom_range(40, 2);
            int hi  = $urandom_range(per - 1, 1);
            for (int c = 0; c < 4 * per + 4; c++) begin
                pwm_in = ((c % per) < hi);
                @(negedge clock);
                n_chk++;
                if (valid !== m_valid || int'(period) !== m_period || int'(high_time) !== m_high ||
                    int'(duty_code) !== m_duty || no_signal !== m_ns || stuck_level !== m_stuck) begin
                    n_fail++;
                    $display("FAIL random r=%0d c=%0d: got %s, required %s", r, c, dut_str(), mdl_str());
                end
            end
            n_chk++;
            if (int'(period) !== per || int'(high_time) !== hi || int'(duty_code) !== duty_of(hi, per)) begin
                n_fail++;
                $display("FAIL random_result r=%0d: got %s, required p=%0d h=%0d d=%0d", r, dut_str(), per, hi, duty_of(hi, per));
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_timeout_high();
        test_low_resume();
        test_duty_edges();
        test_enable_gap();
        test_reset_mid();
        test_max_period();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
